// File: rtl/yc_conf_loader.sv
// yc_conf_loader
// Serial configuration loader for a chain of ycconfig cells. Each accepted
// 3-bit code is shifted into the chain msb first. Every bit is held on
// cbitin for HALF clk cycles with confclk low (LO), then HALF cycles with
// confclk high (HI). The chain captures on the rising edge of confclk. The
// bit leaving the far end of the chain (cbitout) is sampled in the last LO
// cycle, so the code displaced by each load comes back on rb_code.
//
// Ports
//   clk, reset_n   system clock, asynchronous active-low reset
//   restart        synchronous abort; clears the cell counter and readback
//   in_valid/in_code/in_ready  code input handshake (see below)
//   confclk, cbitin            registered clock/data to the chain
//   cbitout                    serial bit returned from the last cell
//   rb_valid/rb_code           one-cycle pulse carrying the displaced code
//   busy                       a code is being shifted
//   done                       one-cycle pulse when CELLS codes have loaded
//   dbg_state                  current FSM state (0 IDLE, 1 LO, 2 HI)
//
// Handshake: a code transfers on a rising clk edge where in_valid=1,
// in_ready=1 and restart=0. in_ready is 1 exactly in IDLE. in_valid
// while busy is ignored and the offered code is left untouched.
module yc_conf_loader #(
  parameter int CELLS = 16,
  parameter int HALF  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       restart,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic       confclk,
  output logic       cbitin,
  input  logic       cbitout,
  output logic       rb_valid,
  output logic [2:0] rb_code,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(CELLS + 1);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(CELLS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [1:0]    bit_q, bit_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    sh_q, sh_d;
  logic [CW-1:0] cell_q, cell_d;
  logic          confclk_q, confclk_d;
  logic          cbitin_q, cbitin_d;
  logic          rb_valid_q, rb_valid_d;
  logic [2:0]    rb_code_q, rb_code_d;
  logic          done_q, done_d;
  logic          half_last;

  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    bit_d      = bit_q;
    code_d     = code_q;
    sh_d       = sh_q;
    cell_d     = cell_q;
    cbitin_d   = cbitin_q;
    rb_valid_d = 1'b0;
    rb_code_d  = rb_code_q;
    done_d     = 1'b0;
    half_last  = (half_q == HALF_LAST);

    if (restart) begin
      state_d   = S_IDLE;
      half_d    = '0;
      bit_d     = 2'd0;
      sh_d      = 3'b000;
      cell_d    = '0;
      cbitin_d  = 1'b0;
      rb_code_d = 3'b000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            code_d   = in_code;
            bit_d    = 2'd2;
            half_d   = '0;
            // The code register loads on this same edge, so take the msb
            // straight from the input.
            cbitin_d = in_code[2];
            state_d  = S_LO;
          end
        end
        S_LO: begin
          if (half_last) begin
            // Last LO cycle: cbitout still shows the bit the coming rising
            // confclk edge will push out of the chain.
            sh_d    = {sh_q[1:0], cbitout};
            half_d  = '0;
            state_d = S_HI;
          end else begin
            half_d = half_q + HW'(1);
          end
        end
        S_HI: begin
          if (half_last) begin
            half_d = '0;
            if (bit_q != 2'd0) begin
              bit_d    = bit_q - 2'd1;
              cbitin_d = code_q[bit_q - 2'd1];
              state_d  = S_LO;
            end else begin
              state_d    = S_IDLE;
              rb_valid_d = 1'b1;
              rb_code_d  = sh_q;
              if (cell_q == CELL_LAST) begin
                cell_d = '0;
                done_d = 1'b1;
              end else begin
                cell_d = cell_q + CW'(1);
              end
            end
          end else begin
            half_d = half_q + HW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // confclk is registered and follows the state being entered, so it is
    // high for exactly the HI cycles.
    confclk_d = (state_d == S_HI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      half_q     <= '0;
      bit_q      <= 2'd0;
      code_q     <= 3'b000;
      sh_q       <= 3'b000;
      cell_q     <= '0;
      confclk_q  <= 1'b0;
      cbitin_q   <= 1'b0;
      rb_valid_q <= 1'b0;
      rb_code_q  <= 3'b000;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      code_q     <= code_d;
      sh_q       <= sh_d;
      cell_q     <= cell_d;
      confclk_q  <= confclk_d;
      cbitin_q   <= cbitin_d;
      rb_valid_q <= rb_valid_d;
      rb_code_q  <= rb_code_d;
      done_q     <= done_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign confclk   = confclk_q;
  assign cbitin    = cbitin_q;
  assign rb_valid  = rb_valid_q;
  assign rb_code   = rb_code_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_yc_conf_loader.sv
module tb_yc_conf_loader;

  localparam int A_CELLS = 4;
  localparam int A_HALF  = 2;
  localparam int B_CELLS = 2;
  localparam int B_HALF  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT a: HALF=2, CELLS=4 ----------------
  logic       restart_a, in_valid_a, in_ready_a, confclk_a, cbitin_a, cbitout_a;
  logic       rb_valid_a, busy_a, done_a;
  logic [2:0] in_code_a, rb_code_a;
  logic [1:0] state_a;

  yc_conf_loader #(.CELLS(A_CELLS), .HALF(A_HALF)) u_a (
    .clk(clk), .reset_n(reset_n), .restart(restart_a),
    .in_valid(in_valid_a), .in_code(in_code_a), .in_ready(in_ready_a),
    .confclk(confclk_a), .cbitin(cbitin_a), .cbitout(cbitout_a),
    .rb_valid(rb_valid_a), .rb_code(rb_code_a), .busy(busy_a),
    .done(done_a), .dbg_state(state_a)
  );

  // ---------------- DUT b: HALF=1, CELLS=2 ----------------
  logic       restart_b, in_valid_b, in_ready_b, confclk_b, cbitin_b, cbitout_b;
  logic       rb_valid_b, busy_b, done_b;
  logic [2:0] in_code_b, rb_code_b;
  logic [1:0] state_b;

  yc_conf_loader #(.CELLS(B_CELLS), .HALF(B_HALF)) u_b (
    .clk(clk), .reset_n(reset_n), .restart(restart_b),
    .in_valid(in_valid_b), .in_code(in_code_b), .in_ready(in_ready_b),
    .confclk(confclk_b), .cbitin(cbitin_b), .cbitout(cbitout_b),
    .rb_valid(rb_valid_b), .rb_code(rb_code_b), .busy(busy_b),
    .done(done_b), .dbg_state(state_b)
  );

  // ycconfig chains: each cell is a 3-bit shift register clocked by confclk;
  // bits [2:0] are the near cell, the top 3 bits the far cell.
  logic [3*A_CELLS-1:0] chain_a = '0;
  logic [3*B_CELLS-1:0] chain_b = '0;
  always @(posedge confclk_a) chain_a <= {chain_a[3*A_CELLS-2:0], cbitin_a};
  always @(posedge confclk_b) chain_b <= {chain_b[3*B_CELLS-2:0], cbitin_b};
  assign cbitout_a = chain_a[3*A_CELLS-1];
  assign cbitout_b = chain_b[3*B_CELLS-1];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_a_q[$];  // {done, rb_code}
  logic [3:0] exp_b_q[$];
  logic [2:0] acc_b_q[$];  // codes in the order b must accept them

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired before the expected event (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin : mon_a
    logic [3:0] e;
    if (reset_n) begin
      if (rb_valid_a) begin
        if (exp_a_q.size() == 0) check("a_rb_unexpected", rb_valid_a, 1'b0);
        else begin
          e = exp_a_q.pop_front();
          check("a_rb_code", rb_code_a, e[2:0]);
          check("a_done", done_a, e[3]);
        end
      end else if (done_a) begin
        check("a_done_stray", done_a, 1'b0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [3:0] e;
    if (reset_n) begin
      if (rb_valid_b) begin
        if (exp_b_q.size() == 0) check("b_rb_unexpected", rb_valid_b, 1'b0);
        else begin
          e = exp_b_q.pop_front();
          check("b_rb_code", rb_code_b, e[2:0]);
          check("b_done", done_b, e[3]);
        end
      end else if (done_b) begin
        check("b_done_stray", done_b, 1'b0);
      end
    end
  end

  always @(negedge clk) begin : mon_acc_b
    logic [2:0] c;
    if (reset_n && in_valid_b && in_ready_b && !restart_b) begin
      if (acc_b_q.size() == 0) check("b_accept_unexpected", in_valid_b, 1'b0);
      else begin
        c = acc_b_q.pop_front();
        check("b_accept_code", in_code_b, c);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_b(input logic [2:0] rb, input logic d);
    exp_b_q.push_back({d, rb});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_b(input logic [2:0] code, input bit keep);
    bit ok;
    ok = 1'b0;
    acc_b_q.push_back(code);
    in_valid_b = 1'b1;
    in_code_b  = code;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready_b) ok = 1'b1;
    end
    if (!ok) fail_now("b_accept_timeout");
    @(posedge clk);
    #1;
    if (!keep) in_valid_b = 1'b0;
  endtask

  task automatic wait_idle_b();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (!busy_b) ok = 1'b1;
    end
    if (!ok) fail_now("b_idle_timeout");
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [2:0] c;
    int rises, t0, t1, t2;
    bit prev, ok;

    reset_n = 1'b0;
    restart_a = 1'b0; in_valid_a = 1'b0; in_code_a = 3'b000;
    restart_b = 1'b0; in_valid_b = 1'b0; in_code_b = 3'b000;
    #1;
    check("rst_a_in_ready", in_ready_a, 1'b1);
    check("rst_a_confclk", confclk_a, 1'b0);
    check("rst_a_cbitin", cbitin_a, 1'b0);
    check("rst_a_busy", busy_a, 1'b0);
    check("rst_a_rb_valid", rb_valid_a, 1'b0);
    check("rst_a_rb_code", rb_code_a, 3'b000);
    check("rst_a_done", done_a, 1'b0);
    check("rst_b_in_ready", in_ready_b, 1'b1);
    check("rst_b_busy", busy_b, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- a: code 001, waveform and timing ----
    exp_a_q.push_back({1'b0, 3'b000});
    c = 3'b001;
    in_valid_a = 1'b1;
    in_code_a  = c;
    @(negedge clk);
    check("a_ready_first", in_ready_a, 1'b1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int k = 1; k <= 6 * A_HALF; k++) begin
      @(negedge clk);
      check("a_confclk", confclk_a, ((k - 1) / A_HALF) % 2);
      check("a_cbitin", cbitin_a, c[2 - (k - 1) / (2 * A_HALF)]);
      check("a_in_ready_busy", in_ready_a, 1'b0);
      if (confclk_a && !prev) rises++;
      prev = confclk_a;
    end
    @(negedge clk);
    check("a_ready_after", in_ready_a, 1'b1);
    check("a_confclk_idle", confclk_a, 1'b0);
    check("a_confclk_pulses", rises, 3);

    // ---- a: asynchronous reset in the middle of HI ----
    @(posedge clk);
    #1;
    in_valid_a = 1'b1;
    in_code_a  = 3'b111;
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (confclk_a) ok = 1'b1;
    end
    if (!ok) fail_now("a_hi_timeout");
    check("a_cbitin_pre_reset", cbitin_a, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_confclk", confclk_a, 1'b0);
    check("arst_cbitin", cbitin_a, 1'b0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_rb_valid", rb_valid_a, 1'b0);
    check("arst_done", done_a, 1'b0);
    check("arst_in_ready", in_ready_a, 1'b1);
    repeat (3) @(negedge clk);
    check("arst_confclk_held", confclk_a, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ---- b: 101 then 011 back-to-back ----
    expect_b(3'b000, 1'b0); send_b(3'b101, 1'b0);
    expect_b(3'b000, 1'b1); send_b(3'b011, 1'b0);
    wait_idle_b();
    check("b_far_cell_1", chain_b[5:3], 3'b101);
    check("b_near_cell_1", chain_b[2:0], 3'b011);

    // ---- b: reload with 110, 111; readback of the previous load ----
    expect_b(3'b101, 1'b0); send_b(3'b110, 1'b0);
    expect_b(3'b011, 1'b1); send_b(3'b111, 1'b0);
    wait_idle_b();
    check("b_far_cell_2", chain_b[5:3], 3'b110);
    check("b_near_cell_2", chain_b[2:0], 3'b111);

    // ---- b: restart after the second confclk rising edge ----
    send_b(3'b011, 1'b0);
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 20 && rises < 2; n++) begin
      @(negedge clk);
      if (confclk_b && !prev) rises++;
      prev = confclk_b;
    end
    if (rises < 2) fail_now("b_rise_timeout");
    @(posedge clk);
    #1;
    restart_b = 1'b1;
    @(posedge clk);
    #1;
    restart_b = 1'b0;
    @(negedge clk);
    check("rs_in_ready", in_ready_b, 1'b1);
    check("rs_busy", busy_b, 1'b0);
    check("rs_confclk", confclk_b, 1'b0);
    check("rs_cbitin", cbitin_b, 1'b0);
    check("rs_rb_valid", rb_valid_b, 1'b0);
    check("rs_done", done_b, 1'b0);
    @(posedge clk);
    #1;
    expect_b(3'b011, 1'b0); send_b(3'b100, 1'b0);
    expect_b(3'b101, 1'b1); send_b(3'b001, 1'b0);
    wait_idle_b();

    // ---- b: in_valid held high across three codes ----
    expect_b(3'b100, 1'b0); send_b(3'b100, 1'b1); t0 = cyc;
    expect_b(3'b001, 1'b1); send_b(3'b010, 1'b1); t1 = cyc;
    expect_b(3'b100, 1'b0); send_b(3'b001, 1'b0); t2 = cyc;
    check("b_gap_1", t1 - t0, 6 * B_HALF + 1);
    check("b_gap_2", t2 - t1, 6 * B_HALF + 1);
    wait_idle_b();
    check("b_far_cell_3", chain_b[5:3], 3'b010);
    check("b_near_cell_3", chain_b[2:0], 3'b001);

    // ---- final report ----
    repeat (2) @(negedge clk);
    check("a_rb_left", exp_a_q.size(), 0);
    check("b_rb_left", exp_b_q.size(), 0);
    check("b_acc_left", acc_b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
